rf_port_ctrl: RTL and testbench
===============================

# rf_port_ctrl

Write-port arbiter and sequencer for the 32 x 32-bit integer register file. It shares the file's single write port between three sources: the pipeline writeback stage, a bulk-clear sequencer and a debug-host write channel. It sits between writeback and the register file write inputs (we / wraddr / wrdata). Writeback has zero-latency priority, so the register file's read-bypass timing is unchanged.

## Interface
Parameters:
- STARVE_LIMIT, default 8: consecutive waiting cycles of a debug request before stall_req is raised; legal range 1..255.
- CNT_W, default 8: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wb_we  in  1  writeback write request; never stalled.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- clr_start  in  1  one-cycle pulse that starts a bulk clear of x1..x31.
- dbg_req  in  1  debug write request; held until dbg_ack.
- dbg_addr  in  5  debug destination; stable while dbg_req=1.
- dbg_wdata  in  32  debug data; stable while dbg_req=1.
- rf_we  out  1  register file write enable (combinational).
- rf_wraddr  out  5  register file write address (combinational).
- rf_wrdata  out  32  register file write data (combinational).
- dbg_ack  out  1  registered one-cycle acknowledge of a debug write.
- clr_busy  out  1  registered; high while the clear sequence is in progress.
- clr_done  out  1  registered one-cycle pulse after the x31 clear write.
- stall_req  out  1  asks the pipeline to freeze writeback; the pipeline is required to drop wb_we.

## Operation
- State machine: IDLE, CLEAR, ACK.
  - ACK lasts exactly one cycle, with dbg_ack=1.
  - ACK returns to IDLE. From ACK, a clr_start goes straight to CLEAR.
- Priority in each cycle: wb_we, then CLEAR-state write, then debug.
  - The losing source's inputs are ignored for that cycle.
- Writeback: when wb_we=1, the rf_* outputs equal wb_we / wb_addr / wb_data in the same cycle.
  - Writes to address 0 are passed through unchanged; the register file ignores them.
- Clear sequencer:
  - In IDLE or ACK, clr_start=1 loads ptr=1 and enters CLEAR.
  - In CLEAR, clr_start is ignored.
  - In CLEAR with wb_we=0: rf_we=1, rf_wraddr=ptr, rf_wrdata=0, then ptr increments.
  - In CLEAR with wb_we=1: ptr holds.
  - The write at ptr=31 returns to IDLE and pulses clr_done in the next cycle.
  - A writeback to an already-cleared register during CLEAR persists. This is accepted behaviour.
- Debug write:
  - Granted in IDLE when dbg_req=1 and wb_we=0, unless clr_start=1 in that cycle; clear wins.
  - Grant cycle with dbg_addr!=0: rf_we=1, rf_wraddr=dbg_addr, rf_wrdata=dbg_wdata.
  - Grant cycle with dbg_addr=0: rf_we=0. The request is still acknowledged.
  - After any grant, go to ACK.
  - The host must drop dbg_req in the ACK cycle; dbg_req is not sampled in ACK.
- Starvation counter:
  - Increments each IDLE cycle in which dbg_req=1 and no grant occurs.
  - Saturates at STARVE_LIMIT.
  - Frozen in CLEAR.
  - Cleared on grant.
- stall_req = clr_busy OR (counter == STARVE_LIMIT).
  - It stays high until the grant; it is low in the ACK cycle unless clr_busy=1.
- When no source is active: rf_we=0, rf_wraddr=0, rf_wrdata=0.

## Timing
- Reset values:
  - Outputs: rf_we=0, rf_wraddr=0, rf_wrdata=0, dbg_ack=0, clr_busy=0, clr_done=0, stall_req=0.
  - Internal: state=IDLE, ptr=1, counter=0.
- Writeback to rf_* has 0-cycle latency (combinational path).
- Debug: write in the grant cycle N; dbg_ack=1 in N+1 only.
- Clear timing:
  - clr_start in cycle N gives clr_busy=1 from N+1.
  - The first clear write is in N+1.
  - With no writeback interference, the last write (x31) is in N+31 and clr_busy falls at N+32.
  - clr_done=1 in N+32.
  - Each writeback cycle during CLEAR extends these times by 1.
- Reset asserted mid-clear aborts immediately. No clr_done is issued, and registers already cleared stay cleared.

## Test plan
- Bulk clear: clr_start pulse, wb_we=0 -> rf_we=1 for 31 consecutive cycles with rf_wraddr 1..31 and rf_wrdata=0; clr_done for one cycle after the x31 write; stall_req high for all 31 cycles.
- Writeback during clear: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF on clear cycles 5 and 6 -> rf_* show 3 / 0xDEADBEEF in those cycles; clear addresses resume at 5; clr_busy lasts 33 cycles.
- Debug write: dbg_req with addr=10, data=0x0000003C, idle pipeline -> rf_we=1, rf_wraddr=10 in the same cycle; dbg_ack in the next cycle; stall_req stays 0.
- Starvation: dbg_req held while wb_we=1 continuously -> stall_req rises after 8 waiting cycles; drop wb_we at cycle 10 -> grant that cycle, dbg_ack next cycle, stall_req=0 in the ACK cycle.
- Debug to x0: dbg_addr=0 -> rf_we stays 0; dbg_ack pulses once.
- Reset mid-clear: rst_n low when ptr=12 -> all outputs 0 immediately; no clr_done; the next clr_start starts again at x1.

Source files
------------

// File: rtl/rf_port_ctrl.sv
// Write-port arbiter for the 32x32 integer register file: writeback, bulk-clear
// sequencer and debug-host writes share the single write port.
module rf_port_ctrl #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        clr_start,
   input  logic        dbg_req,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        rf_we,
   output logic [4:0]  rf_wraddr,
   output logic [31:0] rf_wrdata,
   output logic        dbg_ack,
   output logic        clr_busy,
   output logic        clr_done,
   output logic        stall_req
);

   typedef enum logic [1:0] {IDLE, CLEAR, ACK} state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           state;
   logic [4:0]       ptr;
   logic [CNT_W-1:0] cnt;
   logic             clr_go;
   logic             clr_wr;
   logic             grant;

   assign clr_go = clr_start && (state != CLEAR);
   assign clr_wr = (state == CLEAR) && !wb_we;
   // A clear request in the same cycle beats a pending debug write.
   assign grant  = (state == IDLE) && dbg_req && !wb_we && !clr_start;

   always_comb begin
      rf_we     = 1'b0;
      rf_wraddr = 5'd0;
      rf_wrdata = 32'd0;
      if (wb_we) begin
         rf_we     = 1'b1;
         rf_wraddr = wb_addr;
         rf_wrdata = wb_data;
      end else if (state == CLEAR) begin
         rf_we     = 1'b1;
         rf_wraddr = ptr;
      end else if (grant && dbg_addr != 5'd0) begin
         rf_we     = 1'b1;
         rf_wraddr = dbg_addr;
         rf_wrdata = dbg_wdata;
      end
   end

   assign stall_req = clr_busy || (cnt == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 5'd1;
         cnt      <= '0;
         dbg_ack  <= 1'b0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         dbg_ack  <= 1'b0;
         clr_done <= 1'b0;
         case (state)
            IDLE, ACK: begin
               if (clr_go) begin
                  state    <= CLEAR;
                  ptr      <= 5'd1;
                  clr_busy <= 1'b1;
               end else if (grant) begin
                  state   <= ACK;
                  dbg_ack <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            CLEAR: begin
               // Writeback steals the port; the pointer simply waits.
               if (clr_wr) begin
                  if (ptr == 5'd31) begin
                     state    <= IDLE;
                     ptr      <= 5'd1;
                     clr_busy <= 1'b0;
                     clr_done <= 1'b1;
                  end else begin
                     ptr <= ptr + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (grant)
            cnt <= '0;
         else if (state == IDLE && dbg_req && cnt != LIMIT)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Self-checking bench for rf_port_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based model of the write-port rules.
module tb_rf_port_ctrl;

   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_we, clr_start, dbg_req;
   logic [4:0]  wb_addr, dbg_addr;
   logic [31:0] wb_data, dbg_wdata;
   logic        rf_we, dbg_ack, clr_busy, clr_done, stall_req;
   logic [4:0]  rf_wraddr;
   logic [31:0] rf_wrdata;

   int nchk = 0;
   int nerr = 0;

   rf_port_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .clr_start(clr_start),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .rf_we(rf_we), .rf_wraddr(rf_wraddr), .rf_wrdata(rf_wrdata),
      .dbg_ack(dbg_ack), .clr_busy(clr_busy), .clr_done(clr_done),
      .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   wire [41:0] obs = {rf_we, rf_wraddr, rf_wrdata, dbg_ack, clr_busy, clr_done, stall_req};

   // Model: remaining clear addresses as a queue, plus pending ack/done flags.
   int        m_q[$];
   bit        m_ack, m_done;
   int        m_wait;
   logic [41:0] exp_vec;

   task automatic mdl_reset();
      m_q.delete();
      m_ack  = 1'b0;
      m_done = 1'b0;
      m_wait = 0;
   endtask

   function automatic bit mdl_idle();
      return (m_q.size() == 0) && !m_ack;
   endfunction

   function automatic bit mdl_grant();
      return mdl_idle() && dbg_req && !wb_we && !clr_start;
   endfunction

   task automatic mdl_eval();
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      bit          busy;
      we = 1'b0; a = 5'd0; d = 32'd0;
      busy = m_q.size() != 0;
      if (wb_we) begin
         we = 1'b1; a = wb_addr; d = wb_data;
      end else if (busy) begin
         we = 1'b1; a = 5'(m_q[0]);
      end else if (mdl_grant() && dbg_addr != 0) begin
         we = 1'b1; a = dbg_addr; d = dbg_wdata;
      end
      exp_vec = {we, a, d, m_ack, busy, m_done, busy || (m_wait == LIMIT)};
   endtask

   task automatic mdl_clock();
      bit g, idle;
      g    = mdl_grant();
      idle = mdl_idle();
      m_done = 1'b0;
      if (m_q.size() != 0) begin
         if (!wb_we) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1'b1;
         end
      end else if (clr_start) begin
         for (int k = 1; k <= 31; k++) m_q.push_back(k);
      end
      if (g) m_wait = 0;
      else if (idle && dbg_req && m_wait < LIMIT) m_wait++;
      m_ack = g;
   endtask

   task automatic drive_quiet();
      wb_we = 0; wb_addr = 0; wb_data = 0; clr_start = 0;
      dbg_req = 0; dbg_addr = 0; dbg_wdata = 0;
   endtask

   task automatic advance();
      mdl_clock();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      drive_quiet();
      rst_n = 1'b0;
      mdl_reset();
      #12;
      nchk++;
      if (obs !== 42'd0) begin
         nerr++; $display("FAIL reset outputs: got %h want 0", obs);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); mdl_eval();
      nchk++;
      if (obs !== exp_vec) begin
         nerr++; $display("FAIL reset idle: got %h want %h", obs, exp_vec);
      end
      advance();
   endtask

   task automatic test_clear();
      int dones = 0, stalls = 0, writes = 0;
      drive_quiet();
      clr_start = 1;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk); mdl_eval();
         nchk++;
         if (obs !== exp_vec) begin
            nerr++; $display("FAIL clear cyc %0d: got %h want %h", i, obs, exp_vec);
         end
         if (i >= 1 && i <= 31 && rf_we && rf_wraddr == 5'(i) && rf_wrdata == 0) writes++;
         if (clr_done) dones++;
         if (stall_req) stalls++;
         advance();
         clr_start = 0;
      end
      nchk++;
      if (writes != 31 || dones != 1 || stalls != 31) begin
         nerr++; $display("FAIL clear totals: writes=%0d dones=%0d stalls=%0d want 31/1/31", writes, dones, stalls);
      end
   endtask

   task automatic test_wb_during_clear();
      int busy = 0;
      drive_quiet();
      clr_start = 1;
      for (int i = 0; i < 36; i++) begin
         wb_we   = (i == 5 || i == 6);
         wb_addr = wb_we ? 5'd3 : 5'd0;
         wb_data = wb_we ? 32'hDEADBEEF : 32'd0;
         @(negedge clk); mdl_eval();
         nchk++;
         if (obs !== exp_vec) begin
            nerr++; $display("FAIL wb_clear cyc %0d: got %h want %h", i, obs, exp_vec);
         end
         if (i == 7 && rf_wraddr !== 5'd5) begin
            nerr++; $display("FAIL wb_clear resume: got %0d want 5", rf_wraddr);
         end
         if (clr_busy) busy++;
         advance();
         clr_start = 0;
      end
      nchk++;
      if (busy != 33) begin
         nerr++; $display("FAIL wb_clear busy len: got %0d want 33", busy);
      end
   endtask

   task automatic test_dbg_write(input logic [4:0] a, input logic [31:0] d);
      int acks = 0;
      drive_quiet();
      dbg_req = 1; dbg_addr = a; dbg_wdata = d;
      for (int i = 0; i < 4; i++) begin
         if (m_ack) dbg_req = 0;
         @(negedge clk); mdl_eval();
         nchk++;
         if (obs !== exp_vec) begin
            nerr++; $display("FAIL dbg a=%0d cyc %0d: got %h want %h", a, i, obs, exp_vec);
         end
         if (i == 0 && rf_we !== (a != 0)) begin
            nerr++; $display("FAIL dbg grant we: got %b want %b", rf_we, a != 0);
         end
         if (dbg_ack) acks++;
         advance();
      end
      nchk++;
      if (acks != 1) begin
         nerr++; $display("FAIL dbg ack count: got %0d want 1", acks);
      end
   endtask

   task automatic test_starve();
      drive_quiet();
      dbg_req = 1; dbg_addr = 5'd7; dbg_wdata = 32'h1234_5678;
      for (int i = 0; i < 13; i++) begin
         wb_we   = (i < 10);
         wb_addr = 5'd9;
         wb_data = 32'(i);
         if (m_ack) dbg_req = 0;
         @(negedge clk); mdl_eval();
         nchk++;
         if (obs !== exp_vec) begin
            nerr++; $display("FAIL starve cyc %0d: got %h want %h", i, obs, exp_vec);
         end
         if (stall_req !== (i >= 8 && i <= 10)) begin
            nerr++; $display("FAIL starve stall cyc %0d: got %b want %b", i, stall_req, (i >= 8 && i <= 10));
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_clear();
      drive_quiet();
      clr_start = 1;
      for (int i = 0; i < 12; i++) begin
         advance();
         clr_start = 0;
      end
      nchk++;
      if (rf_wraddr !== 5'd12) begin
         nerr++; $display("FAIL midclr ptr: got %0d want 12", rf_wraddr);
      end
      rst_n = 1'b0;
      mdl_reset();
      #1;
      nchk++;
      if (obs !== 42'd0) begin
         nerr++; $display("FAIL midclr reset outputs: got %h want 0", obs);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         clr_start = (i == 1);
         @(negedge clk); mdl_eval();
         nchk++;
         if (obs !== exp_vec) begin
            nerr++; $display("FAIL midclr cyc %0d: got %h want %h", i, obs, exp_vec);
         end
         if (i == 2 && rf_wraddr !== 5'd1) begin
            nerr++; $display("FAIL midclr restart: got %0d want 1", rf_wraddr);
         end
         advance();
      end
      for (int i = 0; i < 34; i++) advance();
   endtask

   task automatic test_random(input int ncyc);
      drive_quiet();
      for (int i = 0; i < ncyc; i++) begin
         wb_we     = ($urandom_range(0, 99) < 40);
         wb_addr   = 5'($urandom_range(0, 31));
         wb_data   = $urandom;
         clr_start = ($urandom_range(0, 99) < 2);
         if (m_ack) dbg_req = 0;
         else if (!dbg_req && $urandom_range(0, 99) < 30) begin
            dbg_req   = 1;
            dbg_addr  = 5'($urandom_range(0, 31));
            dbg_wdata = $urandom;
         end
         @(negedge clk); mdl_eval();
         nchk++;
         if (obs !== exp_vec) begin
            nerr++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_wb_during_clear();
      test_dbg_write(5'd10, 32'h0000003C);
      test_starve();
      test_dbg_write(5'd0, 32'hCAFE_F00D);
      test_reset_mid_clear();
      test_random(600);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
